// File: rtl/controle_enchimento.sv
// Fill-sequence controller feeding the 7-line fill-level bar decoder (level q + blink square wave).
// Optional drain state ESVAZIANDO is enabled by defining ESVAZIAR_EN.
module controle_enchimento #(
  parameter int unsigned TICKS_POR_NIVEL = 4,
  parameter int unsigned BLINK_DIV       = 2,
  parameter int unsigned NIVEL_MAX       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  output logic [3:0] q,
  output logic       frequenciapiscar,
  output logic       enchendo,
  output logic       cheio
);

  localparam int unsigned TW = (TICKS_POR_NIVEL > 1) ? $clog2(TICKS_POR_NIVEL) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_FIM  = TW'(TICKS_POR_NIVEL - 1);
  localparam logic [BW-1:0] BLINK_FIM = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    Q_MAX     = 4'(NIVEL_MAX);

`ifdef ESVAZIAR_EN
  typedef enum logic [2:0] {OCIOSO, ENCHENDO, PAUSADO, CHEIO, ESVAZIANDO} estado_t;
`else
  typedef enum logic [1:0] {OCIOSO, ENCHENDO, PAUSADO, CHEIO} estado_t;
`endif

  estado_t       estado, estado_n;
  logic [TW-1:0] tick, tick_n, tick_run;
  logic [BW-1:0] blink, blink_n, blink_run;
  logic [3:0]    q_n;
  logic          pisca_n, pisca_run, tick_fim, blink_fim;

  // Free-running step values shared by the filling and draining states
  always_comb begin
    tick_fim  = (tick == TICK_FIM);
    blink_fim = (blink == BLINK_FIM);
    tick_run  = tick_fim ? '0 : tick + TW'(1);
    blink_run = blink_fim ? '0 : blink + BW'(1);
    pisca_run = frequenciapiscar ^ blink_fim;
  end

  // Next-state and next-output logic; blink stays cleared unless a state below keeps it running
  always_comb begin
    estado_n = estado;
    q_n      = q;
    tick_n   = tick;
    blink_n  = '0;
    pisca_n  = 1'b0;
    case (estado)
      OCIOSO: begin
        q_n    = '0;
        tick_n = '0;
        if (iniciar && !parar) estado_n = ENCHENDO;
      end
      ENCHENDO: begin
        if (parar) begin
          estado_n = PAUSADO;
        end else begin
          tick_n = tick_run;
          if (tick_fim) begin
            q_n = q + 4'd1;
            if (q_n == Q_MAX) estado_n = CHEIO;
          end
          if (estado_n == ENCHENDO) begin
            blink_n = blink_run;
            pisca_n = pisca_run;
          end
        end
      end
      PAUSADO: begin
        if (parar) begin
          estado_n = OCIOSO;
          q_n      = '0;
          tick_n   = '0;
        end else if (iniciar) begin
          estado_n = ENCHENDO;
        end
      end
      CHEIO: begin
        q_n    = Q_MAX;
        tick_n = '0;
        if (parar) begin
`ifdef ESVAZIAR_EN
          estado_n = ESVAZIANDO;
`else
          estado_n = OCIOSO;
          q_n      = '0;
`endif
        end
      end
`ifdef ESVAZIAR_EN
      ESVAZIANDO: begin
        if (iniciar) begin
          estado_n = ENCHENDO;
          tick_n   = '0;
        end else begin
          tick_n = tick_run;
          if (tick_fim) begin
            q_n = q - 4'd1;
            if (q_n == 4'd0) estado_n = OCIOSO;
          end
          if (estado_n == ESVAZIANDO) begin
            blink_n = blink_run;
            pisca_n = pisca_run;
          end
        end
      end
`endif
      default: begin
        estado_n = OCIOSO;
        q_n      = '0;
        tick_n   = '0;
      end
    endcase
  end

  // State and registered outputs; status flags decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      estado           <= OCIOSO;
      q                <= '0;
      tick             <= '0;
      blink            <= '0;
      frequenciapiscar <= 1'b0;
      enchendo         <= 1'b0;
      cheio            <= 1'b0;
    end else begin
      estado           <= estado_n;
      q                <= q_n;
      tick             <= tick_n;
      blink            <= blink_n;
      frequenciapiscar <= pisca_n;
      enchendo         <= (estado_n == ENCHENDO);
      cheio            <= (estado_n == CHEIO);
    end
  end

endmodule

// File: tb/tb_controle_enchimento.sv
// Directed bench for controle_enchimento: vector table plus hand sequences for reset, full fill, CHEIO and drain.
module tb_controle_enchimento;

  logic       clk = 1'b0;
  logic       reset, iniciar, parar;
  logic [3:0] q;
  logic       frequenciapiscar, enchendo, cheio;
  int         n_pass = 0;
  int         n_total = 0;

  controle_enchimento dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .parar(parar),
    .q(q), .frequenciapiscar(frequenciapiscar), .enchendo(enchendo), .cheio(cheio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ini;
    logic       par;
    logic [3:0] q;
    logic       p;
    logic       e;
    logic       c;
  } vec_t;

  vec_t tab[23];

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic chk_all(input string name, input logic [3:0] eq, input logic ep,
                         input logic ee, input logic ec);
    chk({name, ".q"}, q, eq);
    chk({name, ".piscar"}, {3'b0, frequenciapiscar}, {3'b0, ep});
    chk({name, ".enchendo"}, {3'b0, enchendo}, {3'b0, ee});
    chk({name, ".cheio"}, {3'b0, cheio}, {3'b0, ec});
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge
  task automatic step(input logic i, input logic p);
    iniciar = i;
    parar   = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ini par q p e c : one edge per row, expected values after that edge
    tab[0]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tab[3]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tab[4]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tab[5]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    tab[6]  = '{1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    tab[7]  = '{1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
    tab[10] = '{1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
    tab[11] = '{1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
    tab[12] = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
    tab[13] = '{1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    tab[14] = '{1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    tab[15] = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
    tab[16] = '{1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
    tab[17] = '{1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0};
    tab[18] = '{1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0};
    tab[19] = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
    tab[20] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tab[21] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tab[22] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    step(1'b1, 1'b0);
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(tab[i].ini, tab[i].par);
      chk_all($sformatf("vec%0d", i), tab[i].q, tab[i].p, tab[i].e, tab[i].c);
    end

    // Synchronous reset held for 3 edges mid-fill at q=3
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("midfill.q", q, 4'd3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk_all($sformatf("rst_hold%0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    step(1'b0, 1'b0);
    chk_all("rst_release", 4'd0, 1'b0, 1'b0, 1'b0);

    // Full fill: q=k/4 after edge E0+k, blink period 4, CHEIO after E24
    step(1'b1, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0);
      chk_all($sformatf("fill_k%0d", k), 4'(k / 4), (k < 24) ? 1'((k / 2) % 2) : 1'b0,
              k < 24, k >= 24);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0);
      chk_all($sformatf("full_hold%0d", k), 4'd6, 1'b0, 1'b0, 1'b1);
    end

    // Simultaneous iniciar/parar in CHEIO
    step(1'b1, 1'b1);
`ifdef ESVAZIAR_EN
    chk_all("cheio_both", 4'd6, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0);
      chk_all($sformatf("drain_k%0d", k), 4'(6 - k / 4),
              (k < 24) ? 1'((k / 2) % 2) : 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    repeat (24) step(1'b0, 1'b0);
    chk("refill.cheio", {3'b0, cheio}, 4'd1);
    step(1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0);
    chk("drain3.q", q, 4'd3);
    step(1'b1, 1'b0);
    chk_all("drain_resume", 4'd3, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("resume_k3.q", q, 4'd3);
    step(1'b0, 1'b0);
    chk_all("resume_k4", 4'd4, 1'b0, 1'b1, 1'b0);
`else
    chk_all("cheio_both", 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_all("cheio_cancel_idle", 4'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
